id_ex_operand_stage: RTL
========================

// Module: id_ex_operand_stage
// PURPOSE
//   ID/EX pipeline register plus EX-stage operand forwarding and ALU control decode.
//   Captures decoded fields from ID each clock and drives operands and control straight into the ALU.
//   Drives Read_data_1, Read_data_2 and a 4-bit ALUControl; forwards results from EX/MEM and MEM/WB.
//   Also supplies the store-data operand, the destination register and the regwrite flag to EX/MEM.
// PARAMETERS
//   DATA_W  32  datapath width (operands, immediate, forwarded results)
//   REG_AW  5   register-number width
//   FWD_EN  1   1 = forwarding enabled; 0 = operands taken only from the register-file copies
// PORTS
//   clk            in   1       rising-edge clock
//   reset          in   1       synchronous, active-high
//   stall          in   1       hold all stage registers
//   flush          in   1       load a bubble
//   id_valid       in   1       ID slot holds a real instruction
//   id_rs_data     in   DATA_W  register-file read of rs
//   id_rt_data     in   DATA_W  register-file read of rt
//   id_imm         in   DATA_W  sign-extended immediate
//   id_rs          in   REG_AW  rs number
//   id_rt          in   REG_AW  rt number
//   id_rd          in   REG_AW  rd number
//   id_alusrc      in   1       1 = operand B is the immediate
//   id_regdst      in   1       1 = destination is rd, 0 = destination is rt
//   id_regwrite    in   1       instruction writes a register
//   id_aluop       in   2       00 add, 01 sub, 10 R-type (decode funct), 11 illegal
//   id_funct       in   6       R-type funct field
//   exmem_regwrite in   1       EX/MEM instruction writes a register
//   exmem_rd       in   REG_AW  EX/MEM destination register
//   exmem_result   in   DATA_W  EX/MEM ALU result
//   memwb_regwrite in   1       MEM/WB instruction writes a register
//   memwb_rd       in   REG_AW  MEM/WB destination register
//   memwb_result   in   DATA_W  MEM/WB write-back value
//   ex_valid       out  1       EX slot holds a real instruction
//   Read_data_1    out  DATA_W  ALU operand A
//   Read_data_2    out  DATA_W  ALU operand B
//   ALUControl     out  4       ALU operation code
//   ex_store_data  out  DATA_W  forwarded rt value, used by sw
//   ex_wreg        out  REG_AW  selected destination register
//   ex_regwrite    out  1       regwrite flag, gated by valid
//   ex_illegal     out  1       ALU operation not decodable
// BEHAVIOUR
// - Stage registers
//   - Reset: all registers clear to 0, except the ALUControl register, which resets to 4'b0010 (add).
//   - Outputs after reset: ex_valid=0, ex_regwrite=0, ex_illegal=0, ex_wreg=0. Read_data_1/2 are 0 unless a forward matches.
//   - Priority on each clock edge: reset > flush > stall > load.
//   - Flush, including flush together with stall: load a bubble (valid=0, regwrite=0, illegal=0, ALUControl=0010, other fields 0).
//   - Stall without flush: every register holds its value.
// - ALU control decode
//   - Decoded in ID and registered, so it takes 1 cycle to appear at the outputs.
//   - aluop 00 -> 0010; aluop 01 -> 0110.
//   - aluop 10 selects on funct: 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001, 101010 -> 0111.
//   - Any other funct, or aluop 11: ALUControl=0010 and ex_illegal=1 (registered only when id_valid=1).
//   - ALUControl never takes a value outside {0000, 0001, 0010, 0110, 0111}.
// - ex_wreg and ex_regwrite
//   - ex_wreg = regdst ? rd : rt, registered.
//   - ex_regwrite = registered (id_regwrite & id_valid & ~illegal).
// - Forwarding
//   - Combinational in EX, computed from the registered rs/rt numbers and data.
//   - Each source operand is resolved as follows:
//     - EX/MEM hit (exmem_regwrite, exmem_rd == src, src != 0) -> exmem_result.
//     - Otherwise MEM/WB hit (memwb_regwrite, memwb_rd == src, src != 0) -> memwb_result.
//     - Otherwise the registered register-file value.
//   - EX/MEM takes priority over MEM/WB; register 0 is never forwarded.
//   - A forward into a bubble (ex_valid=0) is harmless: downstream gating uses ex_regwrite.
//   - FWD_EN=0: all forwarding is bypassed.
// - Operand outputs
//   - Read_data_1 = forwarded rs value.
//   - ex_store_data = forwarded rt value.
//   - Read_data_2 = alusrc ? registered imm : forwarded rt value.
//   - While stalled the registered inputs hold, but the outputs still follow the live forwarding buses.
// - Load-use hazard detection is upstream and arrives here as stall/flush; this block inserts no bubbles itself.
// TESTING
// - Reset: assert reset for 2 cycles with id_valid=1 -> ex_valid=0, ex_regwrite=0, ALUControl=0010.
// - R-type decode: aluop=10 with funct 100010, 100100, 101010, 111111 -> ALUControl 0110, 0000, 0111, then 0010 with ex_illegal=1 and ex_regwrite=0.
// - Double hit: rs=5 with id_rs_data=0x11, exmem(rd=5)=0xAA and memwb(rd=5)=0xBB both writing -> Read_data_1=0xAA. Drop exmem_regwrite -> Read_data_1=0xBB.
// - Register 0: rs=0, exmem(rd=0)=0xFFFF_FFFF writing -> Read_data_1=0.
// - Immediate: alusrc=1, imm=0xFFFF_FFFC, rt forwarded as 0x1234 -> Read_data_2=0xFFFF_FFFC and ex_store_data=0x1234.
// - Stall and flush: stall 3 cycles -> EX fields unchanged. Assert stall and flush together -> ex_valid=0 and ex_regwrite=0 on the next cycle.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and ALU control decode.
// Forwarded operands are combinational on top of the registered ID fields.
module id_ex_operand_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned FWD_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_alusrc,
    input  logic              id_regdst,
    input  logic              id_regwrite,
    input  logic [1:0]        id_aluop,
    input  logic [5:0]        id_funct,
    input  logic              exmem_regwrite,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_regwrite,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic              ex_valid,
    output logic [DATA_W-1:0] Read_data_1,
    output logic [DATA_W-1:0] Read_data_2,
    output logic [3:0]        ALUControl,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_wreg,
    output logic              ex_regwrite,
    output logic              ex_illegal
);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    logic [3:0]        dec_ctl;
    logic              dec_bad;

    logic              valid_q;
    logic [DATA_W-1:0] rs_data_q;
    logic [DATA_W-1:0] rt_data_q;
    logic [DATA_W-1:0] imm_q;
    logic [REG_AW-1:0] rs_q;
    logic [REG_AW-1:0] rt_q;
    logic [REG_AW-1:0] wreg_q;
    logic              alusrc_q;
    logic              regwrite_q;
    logic              illegal_q;
    logic [3:0]        aluctl_q;

    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;

    // ALU control decode in ID; undecodable ops fall back to add and flag illegal
    always_comb begin
        dec_ctl = ALU_ADD;
        dec_bad = 1'b0;
        case (id_aluop)
            2'b00: dec_ctl = ALU_ADD;
            2'b01: dec_ctl = ALU_SUB;
            2'b10: begin
                case (id_funct)
                    6'b100000: dec_ctl = ALU_ADD;
                    6'b100010: dec_ctl = ALU_SUB;
                    6'b100100: dec_ctl = ALU_AND;
                    6'b100101: dec_ctl = ALU_OR;
                    6'b101010: dec_ctl = ALU_SLT;
                    default:   dec_bad = 1'b1;
                endcase
            end
            default: dec_bad = 1'b1;
        endcase
    end

    // Stage registers: reset and flush both load a bubble, stall holds
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid_q    <= 1'b0;
            rs_data_q  <= '0;
            rt_data_q  <= '0;
            imm_q      <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            wreg_q     <= '0;
            alusrc_q   <= 1'b0;
            regwrite_q <= 1'b0;
            illegal_q  <= 1'b0;
            aluctl_q   <= ALU_ADD;
        end else if (!stall) begin
            valid_q    <= id_valid;
            rs_data_q  <= id_rs_data;
            rt_data_q  <= id_rt_data;
            imm_q      <= id_imm;
            rs_q       <= id_rs;
            rt_q       <= id_rt;
            wreg_q     <= id_regdst ? id_rd : id_rt;
            alusrc_q   <= id_alusrc;
            regwrite_q <= id_regwrite & id_valid & ~dec_bad;
            illegal_q  <= id_valid & dec_bad;
            aluctl_q   <= dec_ctl;
        end
    end

    // Forwarding: EX/MEM beats MEM/WB, register 0 is never forwarded
    always_comb begin
        fwd_a = rs_data_q;
        fwd_b = rt_data_q;
        if (FWD_EN != 0) begin
            if (exmem_regwrite && (exmem_rd == rs_q) && (rs_q != '0))
                fwd_a = exmem_result;
            else if (memwb_regwrite && (memwb_rd == rs_q) && (rs_q != '0))
                fwd_a = memwb_result;

            if (exmem_regwrite && (exmem_rd == rt_q) && (rt_q != '0))
                fwd_b = exmem_result;
            else if (memwb_regwrite && (memwb_rd == rt_q) && (rt_q != '0))
                fwd_b = memwb_result;
        end
    end

    assign ex_valid      = valid_q;
    assign Read_data_1   = fwd_a;
    assign Read_data_2   = alusrc_q ? imm_q : fwd_b;
    assign ex_store_data = fwd_b;
    assign ALUControl    = aluctl_q;
    assign ex_wreg       = wreg_q;
    assign ex_regwrite   = regwrite_q;
    assign ex_illegal    = illegal_q;

endmodule
